// File: rtl/button_evt_pkg.sv
// Shared types for the button event classifier: event codes, FSM states, helpers.
package button_evt_pkg;

  localparam int unsigned EvtCodeW = 2;

  typedef enum logic [EvtCodeW-1:0] {
    NONE   = 2'd0,
    SHORT  = 2'd1,
    DOUBLE = 2'd2,
    LONG   = 2'd3
  } evt_code_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS1 = 2'd1,
    WAIT2  = 2'd2,
    HELD   = 2'd3
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Event stream from the classifier FIFO head to its consumer (valid/ready).
interface button_event_ctrl_if;
  import button_evt_pkg::*;

  logic      evt_valid_o;
  evt_code_e evt_code_o;
  logic      evt_ready_i;

  modport master (output evt_valid_o, output evt_code_o, input evt_ready_i);
  modport slave  (input evt_valid_o, input evt_code_o, output evt_ready_i);

endinterface

// File: rtl/evt_fifo.sv
// Small event FIFO with registered head (valid/data) and a drop indication for full pushes.
module evt_fifo #(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  output logic             drop_c,
  output logic             valid,
  output logic [Width-1:0] rdata,
  input  logic             ready
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  rd_ptr_n;
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  count_n;
  logic             full;
  logic             do_push_c;
  logic             do_pop_c;
  logic [Width-1:0] head_n;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop_c  = valid & ready;
    do_push_c = push & (~full | do_pop_c);
    drop_c    = push & full & ~do_pop_c;
    rd_ptr_n  = do_pop_c ? PtrW'(rd_ptr + 1'b1) : rd_ptr;
    count_n   = count + CntW'(do_push_c) - CntW'(do_pop_c);
    head_n    = '0;
    if (count_n != '0) begin
      head_n = (do_push_c && (rd_ptr_n == wr_ptr)) ? wdata : mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      valid  <= 1'b0;
      rdata  <= '0;
    end else begin
      if (do_push_c) begin
        wr_ptr <= PtrW'(wr_ptr + 1'b1);
      end
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      full   <= (count_n == CntW'(Depth));
      valid  <= (count_n != '0);
      rdata  <= head_n;
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Classifies debounced button presses into SHORT / DOUBLE / LONG events and queues them
// for a valid/ready consumer; drops on a full queue are flagged by a sticky overflow.
module button_event_ctrl
  import button_evt_pkg::*;
#(
  parameter int unsigned LongCycles = 50_000_000,
  parameter int unsigned DblCycles  = 25_000_000,
  parameter int unsigned FifoDepth  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                db_level_i,
  input  logic                ovf_clr_i,
  output logic                overflow_o,
  button_event_ctrl_if.master evt
);
  localparam int unsigned TimerMax = max_u(LongCycles, DblCycles);
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0] LongLast = TimerW'(LongCycles - 1);
  localparam logic [TimerW-1:0] DblLast  = TimerW'(DblCycles - 1);

  state_e              state;
  logic [TimerW-1:0]   timer;
  logic                prev_level;
  logic                armed;
  logic                press_edge_c;
  logic                release_edge_c;
  logic                long_hit_c;
  logic                dbl_hit_c;
  logic                push_c;
  evt_code_e           push_code_c;
  logic                drop_c;
  logic [EvtCodeW-1:0] head_code;

  // armed stays low until the level is seen low, so a press held through reset is ignored.
  assign press_edge_c   = db_level_i & ~prev_level & armed;
  assign release_edge_c = ~db_level_i & prev_level;
  assign long_hit_c     = db_level_i & (timer == LongLast);
  assign dbl_hit_c      = (timer == DblLast);

  // Event trigger; written into the FIFO on the same edge the FSM takes the transition.
  always_comb begin
    push_c      = 1'b0;
    push_code_c = NONE;
    if (en_i) begin
      case (state)
        PRESS1: begin
          if (long_hit_c) begin
            push_c      = 1'b1;
            push_code_c = LONG;
          end
        end
        WAIT2: begin
          if (press_edge_c) begin
            push_c      = 1'b1;
            push_code_c = DOUBLE;
          end else if (dbl_hit_c) begin
            push_c      = 1'b1;
            push_code_c = SHORT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      timer      <= '0;
      prev_level <= 1'b0;
      armed      <= 1'b0;
    end else begin
      prev_level <= db_level_i;
      armed      <= armed | ~db_level_i;
      if (!en_i) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        timer <= (timer == '1) ? timer : TimerW'(timer + 1'b1);
        case (state)
          IDLE: begin
            if (press_edge_c) begin
              state <= PRESS1;
              timer <= '0;
            end
          end
          PRESS1: begin
            if (long_hit_c) begin
              state <= HELD;
              timer <= '0;
            end else if (release_edge_c) begin
              state <= WAIT2;
              timer <= '0;
            end
          end
          WAIT2: begin
            if (press_edge_c) begin
              state <= HELD;
              timer <= '0;
            end else if (dbl_hit_c) begin
              state <= IDLE;
              timer <= '0;
            end
          end
          HELD: begin
            if (release_edge_c) begin
              state <= IDLE;
              timer <= '0;
            end
          end
          default: begin
            state <= IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
    end else if (drop_c) begin
      overflow_o <= 1'b1;
    end else if (ovf_clr_i) begin
      overflow_o <= 1'b0;
    end
  end

  evt_fifo #(
    .Width (EvtCodeW),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .push   (push_c),
    .wdata  (push_code_c),
    .drop_c (drop_c),
    .valid  (evt.evt_valid_o),
    .rdata  (head_code),
    .ready  (evt.evt_ready_i)
  );

  assign evt.evt_code_o = evt_code_e'(head_code);

endmodule
